// File: rtl/bcd_7segment_decoder.sv
// Quad seven-segment back end: four registered BCD/status-letter decode lanes
// sharing a mapping select, plus a free-running half-period divider for blink.
module bcd_7segment_decoder #(
    parameter int HALF_PERIOD = 25_000_000
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic [3:0] digit_1000,
    input  logic [3:0] digit_100,
    input  logic [3:0] digit_10,
    input  logic [3:0] digit_1,
    input  logic       c_flag,
    output logic [6:0] segment_1000,
    output logic [6:0] segment_100,
    output logic [6:0] segment_10,
    output logic [6:0] segment_1,
    output logic       blink,
    output logic       blink_tick
);

    localparam int               CNT_W     = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(HALF_PERIOD - 1);
    localparam logic [6:0]       SEG_BLANK = 7'h7F;

    logic [6:0]       seg_1000_p1;
    logic [6:0]       seg_100_p1;
    logic [6:0]       seg_10_p1;
    logic [6:0]       seg_1_p1;
    logic [CNT_W-1:0] cnt;
    logic             blink_q;
    logic             tick_q;

    // Segment order {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] num_map(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            4'd15:   seg = 7'h3F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Status letters: I d l E o n O F -; every other code blanks.
    function automatic logic [6:0] chr_map(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'd1:    seg = 7'h4F;
            4'd2:    seg = 7'h21;
            4'd3:    seg = 7'h47;
            4'd4:    seg = 7'h06;
            4'd5:    seg = 7'h23;
            4'd6:    seg = 7'h2B;
            4'd9:    seg = 7'h40;
            4'd10:   seg = 7'h0E;
            4'd15:   seg = 7'h3F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] code, input logic chr_sel);
        return chr_sel ? chr_map(code) : num_map(code);
    endfunction

    // Stage p0 -> p1: decode lanes registered, divider advanced.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            seg_1000_p1 <= SEG_BLANK;
            seg_100_p1  <= SEG_BLANK;
            seg_10_p1   <= SEG_BLANK;
            seg_1_p1    <= SEG_BLANK;
            cnt         <= '0;
            blink_q     <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            seg_1000_p1 <= seg_decode(digit_1000, c_flag);
            seg_100_p1  <= seg_decode(digit_100, c_flag);
            seg_10_p1   <= seg_decode(digit_10, c_flag);
            seg_1_p1    <= seg_decode(digit_1, c_flag);
            if (cnt == CNT_LAST) begin
                cnt     <= '0;
                blink_q <= ~blink_q;
                tick_q  <= 1'b1;
            end else begin
                cnt     <= cnt + CNT_W'(1);
                tick_q  <= 1'b0;
            end
        end
    end

    assign segment_1000 = seg_1000_p1;
    assign segment_100  = seg_100_p1;
    assign segment_10   = seg_10_p1;
    assign segment_1    = seg_1_p1;
    assign blink        = blink_q;
    assign blink_tick   = tick_q;

endmodule

// File: tb/tb_bcd_7segment_decoder.sv
// Scoreboard bench: a driver issues digit/flag/reset stimulus and queues the
// expected outputs of two divider configurations; a monitor pops and compares.
module tb_bcd_7segment_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] d1000 = '0, d100 = '0, d10 = '0, d1 = '0;
    logic       cf = 1'b0;

    logic [6:0] s1000_a, s100_a, s10_a, s1_a;
    logic       blink_a, tick_a;
    logic [6:0] s1000_b, s100_b, s10_b, s1_b;
    logic       blink_b, tick_b;

    always #5 clk = ~clk;

    bcd_7segment_decoder #(.HALF_PERIOD(4)) dut_a (
        .clk_50M(clk), .rst(rst),
        .digit_1000(d1000), .digit_100(d100), .digit_10(d10), .digit_1(d1),
        .c_flag(cf),
        .segment_1000(s1000_a), .segment_100(s100_a), .segment_10(s10_a), .segment_1(s1_a),
        .blink(blink_a), .blink_tick(tick_a)
    );

    bcd_7segment_decoder #(.HALF_PERIOD(1)) dut_b (
        .clk_50M(clk), .rst(rst),
        .digit_1000(d1000), .digit_100(d100), .digit_10(d10), .digit_1(d1),
        .c_flag(cf),
        .segment_1000(s1000_b), .segment_100(s100_b), .segment_10(s10_b), .segment_1(s1_b),
        .blink(blink_b), .blink_tick(tick_b)
    );

    typedef struct {
        logic [27:0] seg;
        logic        b4;
        logic        t4;
        logic        b1;
        logic        t1;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   k4 = 0;
    int   k1 = 0;
    bit   done = 0;

    // Reference tables, written straight from the display code charts.
    logic [6:0] num_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F};
    logic [6:0] chr_tab [16] = '{7'h7F, 7'h4F, 7'h21, 7'h47, 7'h06, 7'h23, 7'h2B, 7'h7F,
                                 7'h7F, 7'h40, 7'h0E, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F};

    function automatic logic [6:0] ref_seg(input logic [3:0] code, input logic chr);
        return chr ? chr_tab[code] : num_tab[code];
    endfunction

    task automatic drive(input logic r, input logic [15:0] codes, input logic c);
        exp_t e;
        @(negedge clk);
        rst   = r;
        d1000 = codes[15:12];
        d100  = codes[11:8];
        d10   = codes[7:4];
        d1    = codes[3:0];
        cf    = c;
        if (r) begin
            k4 = 0;
            k1 = 0;
            e.seg = {4{7'h7F}};
        end else begin
            k4++;
            k1++;
            e.seg = {ref_seg(codes[15:12], c), ref_seg(codes[11:8], c),
                     ref_seg(codes[7:4], c), ref_seg(codes[3:0], c)};
        end
        e.b4 = ((k4 / 4) % 2) == 1;
        e.t4 = (k4 > 0) && (k4 % 4 == 0);
        e.b1 = (k1 % 2) == 1;
        e.t1 = (k1 > 0);
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are valid every cycle, sampled 1 time unit after the edge.
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("a_seg1000", s1000_a, e.seg[27:21]);
                check("a_seg100",  s100_a,  e.seg[20:14]);
                check("a_seg10",   s10_a,   e.seg[13:7]);
                check("a_seg1",    s1_a,    e.seg[6:0]);
                check("b_seg1000", s1000_b, e.seg[27:21]);
                check("b_seg1",    s1_b,    e.seg[6:0]);
                check("a_blink",   {6'd0, blink_a}, {6'd0, e.b4});
                check("a_tick",    {6'd0, tick_a},  {6'd0, e.t4});
                check("b_blink",   {6'd0, blink_b}, {6'd0, e.b1});
                check("b_tick",    {6'd0, tick_b},  {6'd0, e.t1});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] c;
        // Reset held with arbitrary digits.
        for (int i = 0; i < 3; i++)
            drive(1'b1, 16'($urandom), 1'($urandom));
        // Numeric sweep, a different code on each lane.
        for (int i = 0; i < 16; i++) begin
            c = 4'(i);
            drive(1'b0, {c, c + 4'd5, c + 4'd10, c + 4'd15}, 1'b0);
        end
        // Status words: IdlE, donE, -OF-.
        drive(1'b0, 16'h1234, 1'b1);
        drive(1'b0, 16'h2564, 1'b1);
        drive(1'b0, 16'hF9AF, 1'b1);
        // Mapping flag alone re-maps a held code.
        drive(1'b0, 16'h7777, 1'b0);
        drive(1'b0, 16'h7777, 1'b1);
        drive(1'b0, 16'h7777, 1'b0);
        // Long random run spans many blink periods.
        for (int i = 0; i < 200; i++)
            drive(1'b0, 16'($urandom), 1'($urandom));
        // Reset when the divider count sits at 2.
        drive(1'b1, 16'h0000, 1'b0);
        for (int i = 0; i < 2; i++)
            drive(1'b0, 16'($urandom), 1'($urandom));
        drive(1'b1, 16'($urandom), 1'($urandom));
        for (int i = 0; i < 40; i++)
            drive(1'b0, 16'($urandom), 1'($urandom));
        // Reset released from a random divider phase.
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < int'($urandom_range(1, 7)); j++)
                drive(1'b0, 16'($urandom), 1'($urandom));
            drive(1'b1, 16'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 20; i++)
            drive(1'b0, 16'($urandom), 1'($urandom));
        repeat (3) @(posedge clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        done = 1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
